reg_free_list: RTL

Physical-register free list for the out-of-order pipeline. It is the responder to the decode/dispatch stage's allocation request (take_free_reg), and it receives freed registers from ROB commit (the old destination register). It is a circular FIFO of physical register numbers with first-word-fall-through output, a head-pointer checkpoint output, and a single-cycle restore for branch-mispredict recovery.

---
 rtl/reg_free_list_if.sv | 32 +++
 rtl/reg_free_list.sv | 79 +++++++
 2 files changed

// File: rtl/reg_free_list_if.sv
// Free-list interface: decode allocation, ROB release and mispredict restore
// towards the free list (slave), with head/count/status back to the pipeline.
interface reg_free_list_if #(
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int NUM_PHYS_REGS       = 128,
    parameter int NUM_ARCH_REGS       = 32
);
    localparam int PTR_WIDTH = $clog2(NUM_PHYS_REGS - NUM_ARCH_REGS) + 1;

    // take_free_reg is an acknowledge of the FWFT head, honoured only while
    // !reg_free_list_empty; release_valid and restore_valid are one-cycle strobes.
    logic                           take_free_reg;
    logic [REG_FILE_ADDR_WIDTH-1:0] free_reg_num;
    logic                           reg_free_list_empty;
    logic                           release_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] release_reg;
    logic [PTR_WIDTH-1:0]           head_ptr;
    logic                           restore_valid;
    logic [PTR_WIDTH-1:0]           restore_ptr;
    logic [PTR_WIDTH-1:0]           free_count;
    logic                           overflow_err;

    modport slave (
        input  take_free_reg, release_valid, release_reg, restore_valid, restore_ptr,
        output free_reg_num, reg_free_list_empty, head_ptr, free_count, overflow_err
    );

    modport master (
        output take_free_reg, release_valid, release_reg, restore_valid, restore_ptr,
        input  free_reg_num, reg_free_list_empty, head_ptr, free_count, overflow_err
    );
endinterface

// File: rtl/reg_free_list.sv
// Physical-register free list: circular FIFO of register numbers with FWFT head,
// checkpointable head pointer and single-cycle restore on branch mispredict.
module reg_free_list #(
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int NUM_PHYS_REGS       = 128,
    parameter int NUM_ARCH_REGS       = 32
) (
    input  logic           clk,
    input  logic           reset,
    reg_free_list_if.slave fl
);
    localparam int DEPTH     = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PTR_WIDTH = $clog2(DEPTH) + 1;
    localparam int IDX_W     = PTR_WIDTH - 1;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    logic [REG_FILE_ADDR_WIDTH-1:0] mem_q [DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    logic ovf_q, ovf_d;
    ptr_t count;
    logic full, empty, do_alloc, do_release;

    // DEPTH is not a power of two, so the index wrap and wrap-bit toggle are explicit.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
            return {~p[PTR_WIDTH-1], {IDX_W{1'b0}}};
        return {p[PTR_WIDTH-1], p[IDX_W-1:0] + IDX_W'(1)};
    endfunction

    always_comb begin
        count = '0;
        if (head_q[PTR_WIDTH-1] == tail_q[PTR_WIDTH-1])
            count = {1'b0, tail_q[IDX_W-1:0]} - {1'b0, head_q[IDX_W-1:0]};
        else
            count = ptr_t'(DEPTH) - {1'b0, head_q[IDX_W-1:0]} + {1'b0, tail_q[IDX_W-1:0]};
    end

    assign full       = (count == ptr_t'(DEPTH));
    assign empty      = (count == '0);
    assign do_alloc   = fl.take_free_reg && !empty && !fl.restore_valid;
    assign do_release = fl.release_valid && !full;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ovf_d  = ovf_q | (fl.release_valid && full);
        // Restore wins over allocation; a same-cycle release is older and still lands.
        if (fl.restore_valid)
            head_d = fl.restore_ptr;
        else if (do_alloc)
            head_d = ptr_inc(head_q);
        if (do_release)
            tail_d = ptr_inc(tail_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= {1'b1, {IDX_W{1'b0}}};
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= REG_FILE_ADDR_WIDTH'(NUM_ARCH_REGS + i);
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            if (do_release)
                mem_q[tail_q[IDX_W-1:0]] <= fl.release_reg;
        end
    end

    assign fl.free_reg_num        = mem_q[head_q[IDX_W-1:0]];
    assign fl.reg_free_list_empty = empty;
    assign fl.head_ptr            = head_q;
    assign fl.free_count          = count;
    assign fl.overflow_err        = ovf_q;
endmodule
